// File: rtl/tmr_prog.sv
// Programmable prescaled timer: loadable counter, NUM_CMP sticky compare flags, level irq.
// Define TMR_PROG_AUTORELOAD_EN to add CTRL.ARL (periodic reload at CMP_0).
module tmr_prog #(
    parameter int PRESCALE  = 50000,
    parameter int CNT_WIDTH = 32,
    parameter int NUM_CMP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]     pre_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] cmp_reg [NUM_CMP];
    logic                 run_reg;
    logic                 ovf_reg;
    logic [NUM_CMP-1:0]   ien_reg;
    logic [NUM_CMP-1:0]   mf_reg;
    logic [NUM_CMP-1:0]   mf_set;
    logic [NUM_CMP-1:0]   mf_clr;
    logic [NUM_CMP-1:0]   cmp_wr;
    logic wr_en, cnt_wr, ctrl_wr, stat_wr;
    logic tick, arl, reload, ovf_set;
    logic unused_bits;

    assign wr_en   = stb & we;
    assign cnt_wr  = wr_en && (addr == 3'd0);
    assign ctrl_wr = wr_en && (addr == 3'd1);
    assign stat_wr = wr_en && (addr == 3'd2);

    assign tick     = run_reg && (pre_reg == PRE_LAST);
    assign reload   = tick && arl && (cnt_reg == cmp_reg[0]);
    assign cnt_next = reload ? '0 : cnt_reg + CNT_WIDTH'(1);
    // A CNT load on a tick edge swallows that tick's flag updates.
    assign ovf_set  = tick && !cnt_wr && !reload && (&cnt_reg);
    assign mf_clr   = stat_wr ? data_in[NUM_CMP-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CMP; gi++) begin : g_chan
            assign cmp_wr[gi] = wr_en && (addr == 3'(4 + gi));
            assign mf_set[gi] = tick && !cnt_wr &&
                                ((cnt_next == cmp_reg[gi]) || ((gi == 0) && reload));
        end
    endgenerate

`ifdef TMR_PROG_AUTORELOAD_EN
    logic arl_reg;
    always_ff @(posedge clk) begin
        if (rst)
            arl_reg <= 1'b0;
        else if (ctrl_wr)
            arl_reg <= data_in[1];
    end
    assign arl = arl_reg;
`else
    assign arl = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b1;
            ien_reg <= '0;
            mf_reg  <= '0;
            ovf_reg <= 1'b0;
            for (int i = 0; i < NUM_CMP; i++)
                cmp_reg[i] <= '1;
        end else begin
            if (cnt_wr) begin
                cnt_reg <= data_in[CNT_WIDTH-1:0];
                pre_reg <= '0;
            end else if (tick) begin
                cnt_reg <= cnt_next;
                pre_reg <= '0;
            end else if (run_reg) begin
                pre_reg <= pre_reg + PRE_W'(1);
            end
            if (ctrl_wr) begin
                run_reg <= data_in[0];
                ien_reg <= data_in[4 +: NUM_CMP];
            end
            // Set has priority over a same-edge W1C.
            mf_reg  <= (mf_reg & ~mf_clr) | mf_set;
            ovf_reg <= (ovf_reg & ~(stat_wr & data_in[7])) | ovf_set;
            for (int i = 0; i < NUM_CMP; i++)
                if (cmp_wr[i])
                    cmp_reg[i] <= data_in[CNT_WIDTH-1:0];
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            3'd0: data_out = 32'(cnt_reg);
            3'd1: begin
                data_out[0]            = run_reg;
                data_out[1]            = arl;
                data_out[4 +: NUM_CMP] = ien_reg;
            end
            3'd2: begin
                data_out[NUM_CMP-1:0] = mf_reg;
                data_out[7]           = ovf_reg;
            end
            default: begin
                for (int i = 0; i < NUM_CMP; i++)
                    if (addr == 3'(4 + i))
                        data_out = 32'(cmp_reg[i]);
            end
        endcase
    end

    assign ack = stb;
    assign irq = |(mf_reg & ien_reg);
    assign unused_bits = &{1'b0, data_in};

endmodule

// File: tb/tb_tmr_prog.sv
// Bench for tmr_prog: per-cycle comparison against a register-level model plus directed literal checks.
module tb_tmr_prog;
    localparam int PRESCALE = 4;
    localparam int CW       = 8;
    localparam int NC       = 2;
    localparam int CMOD     = 1 << CW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;

    int checks = 0;
    int errors = 0;

    tmr_prog #(.PRESCALE(PRESCALE), .CNT_WIDTH(CW), .NUM_CMP(NC)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model of the register file
    int          m_cnt, m_pre;
    int          m_cmp [NC];
    bit          m_run, m_arl, m_ovf;
    bit [NC-1:0] m_ien, m_mf;

    always @(posedge clk) begin : model
        bit tick, rel, load;
        int nxt;
        bit [NC-1:0] setv;
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_run = 1; m_arl = 0; m_ovf = 0;
            m_ien = '0; m_mf = '0;
            for (int i = 0; i < NC; i++) m_cmp[i] = CMOD - 1;
        end else begin
            load = stb && we && addr == 3'd0;
            tick = m_run && m_pre == PRESCALE - 1;
            rel  = 0;
            nxt  = (m_cnt + 1) % CMOD;
`ifdef TMR_PROG_AUTORELOAD_EN
            if (m_arl && m_cnt == m_cmp[0]) begin rel = 1; nxt = 0; end
`endif
            setv = '0;
            if (tick && !load)
                for (int i = 0; i < NC; i++)
                    if (nxt == m_cmp[i] || (i == 0 && rel)) setv[i] = 1'b1;
            if (stb && we && addr == 3'd2) begin
                m_mf = m_mf & ~data_in[NC-1:0];
                if (data_in[7]) m_ovf = 0;
            end
            m_mf = m_mf | setv;
            if (tick && !load && !rel && m_cnt == CMOD - 1) m_ovf = 1;
            if (load) begin
                m_cnt = int'(data_in[CW-1:0]);
                m_pre = 0;
            end else begin
                if (tick) m_cnt = nxt;
                if (m_run) m_pre = (m_pre + 1) % PRESCALE;
            end
            if (stb && we && addr == 3'd1) begin
                m_run = data_in[0];
`ifdef TMR_PROG_AUTORELOAD_EN
                m_arl = data_in[1];
`endif
                m_ien = data_in[4 +: NC];
            end
            for (int i = 0; i < NC; i++)
                if (stb && we && addr == 3'(4 + i)) m_cmp[i] = int'(data_in[CW-1:0]);
        end
    end

    function automatic logic [31:0] mread(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r = 32'(m_cnt);
            3'd1: begin r[0] = m_run; r[1] = m_arl; r[4 +: NC] = m_ien; end
            3'd2: begin r[NC-1:0] = m_mf; r[7] = m_ovf; end
            3'd4: r = 32'(m_cmp[0]);
            3'd5: r = 32'(m_cmp[1]);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        logic [31:0] exp_d;
        exp_d = mread(addr);
        checks++;
        if (data_out !== exp_d) begin
            errors++;
            $display("FAIL model_data_out t=%0t addr=%0d actual=0x%0h required=0x%0h", $time, addr, data_out, exp_d);
        end
        checks++;
        if (irq !== |(m_mf & m_ien)) begin
            errors++;
            $display("FAIL model_irq t=%0t actual=%0b required=%0b", $time, irq, |(m_mf & m_ien));
        end
        checks++;
        if (ack !== stb) begin
            errors++;
            $display("FAIL model_ack t=%0t actual=%0b required=%0b", $time, ack, stb);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp_v);
        end else begin
            $display("ok   %s = 0x%0h", nm, act);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0;
        $display("wr   addr=%0d data=0x%0h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, input string nm, input logic [31:0] exp_v);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(nm, data_out, exp_v);
        stb = 1'b0;
    endtask

    task automatic chk_irq(input string nm, input logic exp_v);
        chk(nm, {31'd0, irq}, {31'd0, exp_v});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_ctrl;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values and old-timer behaviour
        rd(3'd0, "reset_cnt", 32'h0);
        rd(3'd1, "reset_ctrl", 32'h1);
        rd(3'd2, "reset_stat", 32'h0);
        rd(3'd4, "reset_cmp0", 32'hFF);
        chk_irq("reset_irq", 1'b0);
        idle(3);
        rd(3'd0, "cnt_edge3", 32'h0);
        idle(1);
        rd(3'd0, "cnt_edge4", 32'h1);
        idle(36);
        rd(3'd0, "cnt_edge40", 32'd10);
        chk_irq("irq_idle", 1'b0);

        // Compare channel 1 with interrupt
        wr(3'd0, 32'h0);
        wr(3'd5, 32'h3);
        wr(3'd1, 32'h21);
        idle(9);
        rd(3'd0, "cnt_before_match", 32'h2);
        chk_irq("irq_before_match", 1'b0);
        idle(1);
        rd(3'd0, "cnt_match", 32'h3);
        rd(3'd2, "stat_mf1", 32'h02);
        chk_irq("irq_mf1", 1'b1);
        wr(3'd2, 32'h02);
        rd(3'd2, "stat_w1c", 32'h0);
        chk_irq("irq_w1c", 1'b0);
        idle(4);
        rd(3'd0, "cnt_after_w1c", 32'h4);

        // Overflow, and a load equal to CMP_0
        wr(3'd0, 32'hFE);
        idle(8);
        rd(3'd0, "cnt_wrap", 32'h0);
        rd(3'd2, "stat_ovf", 32'h81);
        chk_irq("irq_ien0_off", 1'b0);
        wr(3'd2, 32'hFF);
        wr(3'd0, 32'hFF);
        rd(3'd2, "stat_load_eq_cmp", 32'h0);

        // Stop and restart
        idle(2);
        wr(3'd1, 32'h20);
        idle(20);
        rd(3'd0, "cnt_frozen", 32'hFF);
        rd(3'd2, "stat_frozen", 32'h0);
        wr(3'd1, 32'h21);
        rd(3'd0, "cnt_restart_edge", 32'hFF);
        idle(1);
        rd(3'd0, "cnt_resume", 32'h0);
        rd(3'd2, "stat_resume_ovf", 32'h80);

        // CNT load on a tick edge that would have matched CMP_1
        wr(3'd5, 32'h1);
        wr(3'd2, 32'hFF);
        idle(1);
        wr(3'd0, 32'h50);
        rd(3'd0, "cnt_load_on_tick", 32'h50);
        rd(3'd2, "stat_load_on_tick", 32'h0);
        chk_irq("irq_load_on_tick", 1'b0);

        // W1C colliding with a new set
        wr(3'd5, 32'h51);
        idle(3);
        rd(3'd2, "stat_mf1_again", 32'h02);
        chk_irq("irq_mf1_again", 1'b1);
        wr(3'd5, 32'h52);
        idle(2);
        wr(3'd2, 32'h02);
        rd(3'd0, "cnt_collide", 32'h52);
        rd(3'd2, "stat_set_wins", 32'h02);
        wr(3'd2, 32'h02);
        rd(3'd2, "stat_cleared", 32'h0);

        // Unmapped addresses and unused CTRL bits
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd3, "addr3_zero", 32'h0);
        rd(3'd6, "addr6_zero", 32'h0);
        rd(3'd7, "addr7_zero", 32'h0);
        wr(3'd1, 32'hFFFF_FFFF);
`ifdef TMR_PROG_AUTORELOAD_EN
        exp_ctrl = 32'h33;
`else
        exp_ctrl = 32'h31;
`endif
        rd(3'd1, "ctrl_all_ones", exp_ctrl);

        // Auto-reload (or free-run without the feature)
        wr(3'd1, 32'h01);
        wr(3'd2, 32'hFF);
        wr(3'd0, 32'h0);
        wr(3'd4, 32'h5);
        wr(3'd1, 32'h03);
        idle(2);
        for (int k = 1; k <= 13; k++) begin
`ifdef TMR_PROG_AUTORELOAD_EN
            rd(3'd0, "cnt_arl_seq", 32'(k % 6));
`else
            rd(3'd0, "cnt_free_seq", 32'(k));
`endif
            idle(4);
        end
`ifdef TMR_PROG_AUTORELOAD_EN
        exp_ctrl = 32'h03;
`else
        exp_ctrl = 32'h01;
`endif
        rd(3'd1, "ctrl_arl_bit", exp_ctrl);
        rd(3'd2, "stat_mf0_seq", 32'h01);

        // Reset mid-operation while a write is presented
        rst = 1'b1; stb = 1'b1; we = 1'b1; addr = 3'd0; data_in = 32'h77;
        @(posedge clk);
        #1;
        rst = 1'b0; stb = 1'b0; we = 1'b0;
        rd(3'd0, "rerst_cnt", 32'h0);
        rd(3'd1, "rerst_ctrl", 32'h1);
        rd(3'd2, "rerst_stat", 32'h0);
        rd(3'd4, "rerst_cmp0", 32'hFF);
        rd(3'd5, "rerst_cmp1", 32'hFF);
        chk_irq("rerst_irq", 1'b0);
        idle(3);
        rd(3'd0, "rerst_cnt_edge3", 32'h0);
        idle(1);
        rd(3'd0, "rerst_cnt_edge4", 32'h1);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
